// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage
//
// Instruction fetch stage in front of decode. Holds the PC, issues requests
// to a synchronous instruction memory (data returns exactly one cycle after
// the request), buffers returned words in a 2-entry queue and presents the
// queue head to decode. Each head word is pre-sliced into its opcode and the
// packed 12-bit immediate used by the downstream sign extender. A redirect
// from execute flushes the queue and restarts fetch at the new address.
//
// Ports:
//   clk_i, rst_n_i         clock (rising edge), async active-low reset
//   imem_req_o/addr_o      fetch request and byte address (the PC)
//   imem_rdata_i           word returned one cycle after an issued request
//   redirect_i/_pc_i       taken branch/jump: flush and restart at _pc_i
//   instr_valid_o/ready_i  decode handshake on the queue head
//   instr_o, instr_pc_o    head word and its PC
//   instr_type_o           head opcode (instr[6:0])
//   instr_imm_o            packed 12-bit immediate for the sign extender
//
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating counters
//   stall_cnt_o (valid & !ready cycles) and flush_cnt_o (redirects).
//
// Handshake: a transfer happens in any cycle where instr_valid_o and
// instr_ready_i are both high. While valid is high and ready is low the head
// word, PC and derived fields stay unchanged; valid never drops without a
// transfer except on redirect or reset.

module fetch_buffer_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic [6:0]  instr_type_o,
   output logic [11:0] instr_imm_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] tag_q, tag_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        inflight_q, inflight_d;
   logic        drop_q, drop_d;
   logic [31:0] buf_word_q [2];
   logic [31:0] buf_word_d [2];
   logic [31:0] buf_pc_q [2];
   logic [31:0] buf_pc_d [2];

   logic        head_valid;
   logic        deq;
   logic        enq;
   logic        issue;
   logic [2:0]  occupancy;
   logic [31:0] head_word;

   assign head_valid = (count_q != 2'd0);
   assign deq        = head_valid & instr_ready_i;

   // Slots already committed after this cycle: queued entries plus the
   // response arriving now, minus the one decode takes. Issuing only while
   // this is below 2 guarantees the next response always has a free slot.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};

   // Reset is folded in so the request line is low while reset is held,
   // not merely from the first clock edge.
   assign issue = rst_n_i & ~redirect_i & (occupancy < 3'd2);

   // A response coinciding with a redirect belongs to the old stream.
   assign enq = inflight_q & ~drop_q & ~redirect_i;

   always_comb begin
      pc_d       = pc_q;
      tag_d      = tag_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inflight_d = issue;
      drop_d     = 1'b0;
      buf_word_d = buf_word_q;
      buf_pc_d   = buf_pc_q;

      if (redirect_i) begin
         // The dequeue in this cycle (if any) still completes in decode;
         // everything left in the queue is discarded.
         pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         drop_d   = inflight_q;
      end else begin
         if (issue) begin
            pc_d  = pc_q + 32'(PC_STEP);
            tag_d = pc_q;
         end
         if (enq) begin
            buf_word_d[wr_ptr_q] = imem_rdata_i;
            buf_pc_d[wr_ptr_q]   = tag_q;
            wr_ptr_d             = ~wr_ptr_q;
         end
         if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, enq} - {1'b0, deq};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q          <= RESET_PC;
         tag_q         <= '0;
         count_q       <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         inflight_q    <= 1'b0;
         drop_q        <= 1'b0;
         buf_word_q[0] <= '0;
         buf_word_q[1] <= '0;
         buf_pc_q[0]   <= '0;
         buf_pc_q[1]   <= '0;
      end else begin
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         buf_word_q <= buf_word_d;
         buf_pc_q   <= buf_pc_d;
      end
   end

   assign imem_req_o  = issue;
   assign imem_addr_o = pc_q;

   // Data outputs read zero whenever the head is empty so stale entries
   // never leak toward decode.
   assign head_word     = head_valid ? buf_word_q[rd_ptr_q] : 32'h0;
   assign instr_valid_o = head_valid;
   assign instr_o       = head_word;
   assign instr_pc_o    = head_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
   assign instr_type_o  = head_word[6:0];

   always_comb begin
      instr_imm_o = head_word[31:20];
      case (head_word[6:0])
         7'b0100011: instr_imm_o = {head_word[31:25], head_word[11:7]};
         // Branch offset bits 12..1; the extender appends the zero LSB.
         7'b1100011: instr_imm_o = {head_word[31], head_word[7],
                                    head_word[30:25], head_word[11:8]};
         default:    instr_imm_o = head_word[31:20];
      endcase
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (head_valid && !instr_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage: a per-cycle table of inputs and
// hand-computed outputs starting at reset release, followed by a mid-stream
// asynchronous reset and restart sequence.

module tb_fetch_buffer_stage;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [6:0]  instr_type_o;
   logic [11:0] instr_imm_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_buffer_stage dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_type_o  (instr_type_o),
      .instr_imm_o   (instr_imm_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
`endif
   );

   // Synchronous instruction memory: word = address, except a few
   // hand-placed encodings for the immediate-packing checks.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0200: mem_word = 32'hFE00_0EE3;
         32'h0000_0204: mem_word = 32'hFE11_2E23;
         32'h0000_0208: mem_word = 32'h8000_0013;
         32'h0000_020C: mem_word = 32'hABC0_0067;
         default:       mem_word = a;
      endcase
   endfunction

   always @(posedge clk) begin
      imem_rdata_i <= imem_req_o ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] ew;
      logic [6:0]  et;
      logic [11:0] ei;
      logic        ereq;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] ew,
                      input logic [6:0] et, input logic [11:0] ei,
                      input logic ereq, input logic [31:0] eaddr);
      vec_t v;
      v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.ev = ev; v.epc = epc;
      v.ew = ew; v.et = et; v.ei = ei; v.ereq = ereq; v.eaddr = eaddr;
      vecs.push_back(v);
   endtask

   initial begin
      int k;
      //   rdy redir rpc           ev  pc            word          type   imm      req addr
      // start-up, always ready
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h0);        // c0
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h4);        // c1
      add(1, 0, 32'h0,          1, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h8);        // c2
      add(1, 0, 32'h0,          1, 32'h4,         32'h4,         7'h04, 12'h000, 1, 32'hC);        // c3
      // five stall cycles: queue fills to 2, requests stop
      add(0, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 0, 32'h10);       // c4
      add(0, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 0, 32'h10);       // c5
      add(0, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 0, 32'h10);       // c6
      add(0, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 0, 32'h10);       // c7
      add(0, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 0, 32'h10);       // c8
      add(1, 0, 32'h0,          1, 32'h8,         32'h8,         7'h08, 12'h000, 1, 32'h10);       // c9
      add(1, 0, 32'h0,          1, 32'hC,         32'hC,         7'h0C, 12'h000, 1, 32'h14);       // c10
      add(1, 0, 32'h0,          1, 32'h10,        32'h10,        7'h10, 12'h000, 1, 32'h18);       // c11
      // misaligned redirect with a response in flight (0x18 must be dropped)
      add(1, 1, 32'h103,        1, 32'h14,        32'h14,        7'h14, 12'h000, 0, 32'h1C);       // c12
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h100);      // c13
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h104);      // c14
      add(1, 0, 32'h0,          1, 32'h100,       32'h100,       7'h00, 12'h000, 1, 32'h108);      // c15
      // redirect into the immediate-packing words
      add(1, 1, 32'h200,        1, 32'h104,       32'h104,       7'h04, 12'h000, 0, 32'h10C);      // c16
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h200);      // c17
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h204);      // c18
      add(1, 0, 32'h0,          1, 32'h200,       32'hFE000EE3,  7'h63, 12'hFFE, 1, 32'h208);      // c19 B
      add(1, 0, 32'h0,          1, 32'h204,       32'hFE112E23,  7'h23, 12'hFFC, 1, 32'h20C);      // c20 S
      add(1, 0, 32'h0,          1, 32'h208,       32'h80000013,  7'h13, 12'h800, 1, 32'h210);      // c21 I
      add(1, 0, 32'h0,          1, 32'h20C,       32'hABC00067,  7'h67, 12'hABC, 1, 32'h214);      // c22 jalr
      // redirect near the top of the address space to exercise PC wrap
      add(1, 1, 32'hFFFF_FFF8,  1, 32'h210,       32'h210,       7'h10, 12'h000, 0, 32'h218);      // c23
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'hFFFF_FFF8);// c24
      add(1, 0, 32'h0,          0, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'hFFFF_FFFC);// c25
      add(1, 0, 32'h0,          1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 7'h78, 12'hFFF, 1, 32'h0);        // c26
      add(1, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 7'h7C, 12'hFFF, 1, 32'h4);        // c27
      add(1, 0, 32'h0,          1, 32'h0,         32'h0,         7'h00, 12'h000, 1, 32'h8);        // c28

      // clock/reset
      rst_n_i       = 1'b0;
      instr_ready_i = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      chk("rst_req",   {31'h0, imem_req_o},    32'h0);
      chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
      chk("rst_instr", instr_o,                32'h0);
      chk("rst_pc",    instr_pc_o,             32'h0);
      chk("rst_type",  {25'h0, instr_type_o},  32'h0);
      chk("rst_imm",   {20'h0, instr_imm_o},   32'h0);
      chk("rst_addr",  imem_addr_o,            32'h0);
      rst_n_i = 1'b1;

      // table-driven cycles
      foreach (vecs[i]) begin
         instr_ready_i = vecs[i].rdy;
         redirect_i    = vecs[i].redir;
         redirect_pc_i = vecs[i].rpc;
         #1;
         chk($sformatf("c%0d_valid", i), {31'h0, instr_valid_o}, {31'h0, vecs[i].ev});
         chk($sformatf("c%0d_req", i),   {31'h0, imem_req_o},    {31'h0, vecs[i].ereq});
         chk($sformatf("c%0d_addr", i),  imem_addr_o,            vecs[i].eaddr);
         if (vecs[i].ev) begin
            chk($sformatf("c%0d_pc", i),   instr_pc_o,            vecs[i].epc);
            chk($sformatf("c%0d_word", i), instr_o,               vecs[i].ew);
            chk($sformatf("c%0d_type", i), {25'h0, instr_type_o}, {25'h0, vecs[i].et});
            chk($sformatf("c%0d_imm", i),  {20'h0, instr_imm_o},  {20'h0, vecs[i].ei});
         end
         @(posedge clk);
         @(negedge clk);
      end
      redirect_i = 1'b0;

`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", stall_cnt_o, 32'd5);
      chk("flush_cnt", flush_cnt_o, 32'd3);
`endif

      // mid-stream asynchronous reset (queue holds one entry here)
      #2;
      chk("pre_reset_valid", {31'h0, instr_valid_o}, 32'h1);
      rst_n_i = 1'b0;
      #1;
      chk("async_valid", {31'h0, instr_valid_o}, 32'h0);
      chk("async_req",   {31'h0, imem_req_o},    32'h0);
      chk("async_instr", instr_o,                32'h0);
      chk("async_pc",    instr_pc_o,             32'h0);
      chk("async_imm",   {20'h0, instr_imm_o},   32'h0);
      chk("async_addr",  imem_addr_o,            32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("async_stall_cnt", stall_cnt_o, 32'd0);
      chk("async_flush_cnt", flush_cnt_o, 32'd0);
`endif
      instr_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n_i = 1'b1;
      #1;
      chk("restart_req",  {31'h0, imem_req_o}, 32'h1);
      chk("restart_addr", imem_addr_o,         32'h0);

      // bounded wait for the first instruction after restart
      k = 0;
      while (!instr_valid_o && k < 6) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         k++;
      end
      chk("restart_latency", k,           32'd2);
      chk("restart_pc",      instr_pc_o,  32'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("restart_next_pc", instr_pc_o,  32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
